// File: rtl/fifo_ptr_ctrl_pkg.sv
// Shared FIFO constants and helpers, used by the pointer controller, comparator and FIFO top.
// The optional almost flags on fifo_ptr_ctrl are enabled with the FIFO_ALMOST_FLAGS_EN macro.
package fifo_ptr_ctrl_pkg;

    localparam int FIFO_K = 3;

    // Pointers carry one extra wrap bit above the address bits.
    function automatic int ptr_width(input int k);
        return k + 1;
    endfunction

    function automatic int fifo_depth(input int k);
        return 1 << k;
    endfunction

    localparam int FIFO_DEPTH = fifo_depth(FIFO_K);
    localparam int FIFO_PTR_W = ptr_width(FIFO_K);
    localparam int PTR_RST    = 0;

endpackage

// File: rtl/fifo_ptr_cnt.sv
// Wrapping pointer register with synchronous reset and increment enable.
module fifo_ptr_cnt
    import fifo_ptr_ctrl_pkg::*;
#(
    parameter int W = FIFO_PTR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    // NOTE: non-blocking assignment so every register sees pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= W'(PTR_RST);
        end else if (inc) begin
            ptr <= ptr + W'(1);
        end
    end

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Write/read pointer and flag controller for the synchronous FIFO.
// Define FIFO_ALMOST_FLAGS_EN to add the almost_full / almost_empty outputs and ALMOST_TH.
module fifo_ptr_ctrl
    import fifo_ptr_ctrl_pkg::*;
#(
    parameter int K = FIFO_K
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    parameter int ALMOST_TH = 1
`endif
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic         rd_en,
    output logic [K-1:0] wr_addr,
    output logic [K-1:0] rd_addr,
    output logic         wr_accept,
    output logic         rd_accept,
    output logic         full,
    output logic         empty,
    output logic [K:0]   count,
    output logic         overflow,
    output logic         underflow
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    output logic         almost_full,
    output logic         almost_empty
`endif
);

    localparam int PTR_W = ptr_width(K);

    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;

    // NOTE: flags depend only on the registered pointers, so the accept paths never loop back.
    assign wr_accept = wr_en && !full;
    assign rd_accept = rd_en && !empty;

    fifo_ptr_cnt #(.W(PTR_W)) u_wptr (
        .clk (clk),
        .rst (rst),
        .inc (wr_accept),
        .ptr (wptr)
    );

    fifo_ptr_cnt #(.W(PTR_W)) u_rptr (
        .clk (clk),
        .rst (rst),
        .inc (rd_accept),
        .ptr (rptr)
    );

    assign wr_addr = wptr[K-1:0];
    assign rd_addr = rptr[K-1:0];

    // Same address bits with opposite wrap bits means the writer is a full lap ahead.
    assign empty = (wptr == rptr);
    assign full  = (wptr[K] != rptr[K]) && (wptr[K-1:0] == rptr[K-1:0]);
    assign count = wptr - rptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
        end
    end

`ifdef FIFO_ALMOST_FLAGS_EN
    localparam logic [PTR_W-1:0] AF_LEVEL = PTR_W'(fifo_depth(K) - ALMOST_TH);
    localparam logic [PTR_W-1:0] AE_LEVEL = PTR_W'(ALMOST_TH);

    assign almost_full  = (count >= AF_LEVEL);
    assign almost_empty = (count <= AE_LEVEL);
`endif

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Self-checking bench for fifo_ptr_ctrl (K = 3); covers almost flags when FIFO_ALMOST_FLAGS_EN is defined.
module tb_fifo_ptr_ctrl;

    localparam int K     = 3;
    localparam int DEPTH = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr_en = 1'b0;
    logic         rd_en = 1'b0;
    logic [K-1:0] wr_addr;
    logic [K-1:0] rd_addr;
    logic         wr_accept;
    logic         rd_accept;
    logic         full;
    logic         empty;
    logic [K:0]   count;
    logic         overflow;
    logic         underflow;
`ifdef FIFO_ALMOST_FLAGS_EN
    logic         almost_full;
    logic         almost_empty;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef FIFO_ALMOST_FLAGS_EN
    fifo_ptr_ctrl #(.K(K), .ALMOST_TH(2)) dut (
`else
    fifo_ptr_ctrl #(.K(K)) dut (
`endif
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .wr_addr      (wr_addr),
        .rd_addr      (rd_addr),
        .wr_accept    (wr_accept),
        .rd_accept    (rd_accept),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
`ifdef FIFO_ALMOST_FLAGS_EN
        ,
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic wr;
        logic rd;
        logic wa;
        logic ra;
        int   cnt;
        logic f;
        logic e;
        logic o;
        logic u;
        int   waddr;
        int   raddr;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive inputs just after the falling edge, then sample one time unit later.
    task automatic step(input logic w, input logic r, input logic s);
        @(negedge clk);
        wr_en = w;
        rd_en = r;
        rst   = s;
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".count"}, count, 0);
        check({tag, ".empty"}, empty, 1);
        check({tag, ".full"}, full, 0);
        check({tag, ".wr_addr"}, wr_addr, 0);
        check({tag, ".rd_addr"}, rd_addr, 0);
        check({tag, ".overflow"}, overflow, 0);
        check({tag, ".underflow"}, underflow, 0);
`ifdef FIFO_ALMOST_FLAGS_EN
        check({tag, ".almost_full"}, almost_full, 0);
        check({tag, ".almost_empty"}, almost_empty, 1);
`endif
    endtask

    task automatic write_n(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        // Expectations are what is visible in the cycle the inputs are applied.
        //          wr    rd    wa    ra    cnt f     e     o     u     wad rad
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 3, 2};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 3, 3};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 3, 3};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 4, 3};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 4, 3};

        // Reset then idle
        do_reset();
        check_reset_state("reset");
        step(1'b0, 1'b0, 1'b0);
        check_reset_state("idle");

        // Table vectors: underflow, mixed traffic, simultaneous at empty
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].wr, vecs[i].rd, 1'b0);
            check($sformatf("vec%0d.wr_accept", i), wr_accept, vecs[i].wa);
            check($sformatf("vec%0d.rd_accept", i), rd_accept, vecs[i].ra);
            check($sformatf("vec%0d.count", i), count, vecs[i].cnt);
            check($sformatf("vec%0d.full", i), full, vecs[i].f);
            check($sformatf("vec%0d.empty", i), empty, vecs[i].e);
            check($sformatf("vec%0d.overflow", i), overflow, vecs[i].o);
            check($sformatf("vec%0d.underflow", i), underflow, vecs[i].u);
            check($sformatf("vec%0d.wr_addr", i), wr_addr, vecs[i].waddr);
            check($sformatf("vec%0d.rd_addr", i), rd_addr, vecs[i].raddr);
        end

        // Fill to full, then one rejected write
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, 1'b0);
            check($sformatf("fill%0d.wr_accept", i), wr_accept, 1);
            check($sformatf("fill%0d.wr_addr", i), wr_addr, i);
            check($sformatf("fill%0d.count", i), count, i);
            check($sformatf("fill%0d.full", i), full, 0);
        end
        step(1'b1, 1'b0, 1'b0);
        check("wr9.full", full, 1);
        check("wr9.count", count, DEPTH);
        check("wr9.wr_accept", wr_accept, 0);
        check("wr9.wr_addr", wr_addr, 0);
        step(1'b0, 1'b0, 1'b0);
        check("ovf_pulse.overflow", overflow, 1);
        check("ovf_pulse.wr_addr", wr_addr, 0);
        check("ovf_pulse.count", count, DEPTH);
        step(1'b0, 1'b0, 1'b0);
        check("ovf_end.overflow", overflow, 0);

        // Drain to empty, then two rejected reads in a row
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 1'b0);
            check($sformatf("drain%0d.rd_accept", i), rd_accept, 1);
            check($sformatf("drain%0d.rd_addr", i), rd_addr, i);
            check($sformatf("drain%0d.count", i), count, DEPTH - i);
            check($sformatf("drain%0d.empty", i), empty, 0);
        end
        step(1'b0, 1'b1, 1'b0);
        check("rd9.empty", empty, 1);
        check("rd9.rd_accept", rd_accept, 0);
        check("rd9.count", count, 0);
        check("rd9.rd_addr", rd_addr, 0);
        step(1'b0, 1'b1, 1'b0);
        check("udf1.underflow", underflow, 1);
        check("udf1.rd_addr", rd_addr, 0);
        step(1'b0, 1'b0, 1'b0);
        check("udf2.underflow", underflow, 1);
        step(1'b0, 1'b0, 1'b0);
        check("udf_end.underflow", underflow, 0);

        // Simultaneous read/write while full
        write_n(DEPTH);
        step(1'b1, 1'b1, 1'b0);
        check("both_full.full", full, 1);
        check("both_full.wr_accept", wr_accept, 0);
        check("both_full.rd_accept", rd_accept, 1);
        step(1'b0, 1'b0, 1'b0);
        check("both_full.count_after", count, DEPTH - 1);
        check("both_full.overflow", overflow, 1);
        check("both_full.full_after", full, 0);

        // Simultaneous read/write at count 4 for 10 cycles
        do_reset();
        write_n(4);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b0);
            check($sformatf("steady%0d.count", i), count, 4);
        end
        step(1'b0, 1'b0, 1'b0);
        check("steady_end.count", count, 4);

        // Wrap-around bursts (5,6,5,4 entries) against an occupancy model
        do_reset();
        begin
            int bursts[4] = '{5, 6, 5, 4};
            int m_cnt = 0;
            int m_w   = 0;
            int m_r   = 0;
            for (int b = 0; b < 4; b++) begin
                for (int ph = 0; ph < 2; ph++) begin
                    for (int j = 0; j < bursts[b]; j++) begin
                        step(ph == 0, ph == 1, 1'b0);
                        check("wrap.count", count, m_cnt);
                        check("wrap.full", full, m_cnt == DEPTH);
                        check("wrap.empty", empty, m_cnt == 0);
                        check("wrap.wr_addr", wr_addr, m_w % DEPTH);
                        check("wrap.rd_addr", rd_addr, m_r % DEPTH);
`ifdef FIFO_ALMOST_FLAGS_EN
                        check("wrap.almost_full", almost_full, m_cnt >= 6);
                        check("wrap.almost_empty", almost_empty, m_cnt <= 2);
`endif
                        if (ph == 0 && m_cnt < DEPTH) begin
                            m_cnt++;
                            m_w++;
                        end
                        if (ph == 1 && m_cnt > 0) begin
                            m_cnt--;
                            m_r++;
                        end
                    end
                end
            end
            step(1'b0, 1'b0, 1'b0);
            check("wrap_end.empty", empty, 1);
            check("wrap_end.wr_addr", wr_addr, 20 % DEPTH);
            check("wrap_end.rd_addr", rd_addr, 20 % DEPTH);
        end

`ifdef FIFO_ALMOST_FLAGS_EN
        // Almost-flag thresholds across a full fill (ALMOST_TH = 2)
        do_reset();
        for (int i = 0; i <= DEPTH; i++) begin
            step(1'b1, 1'b0, 1'b0);
            check($sformatf("almost%0d.almost_full", i), almost_full, i >= 6);
            check($sformatf("almost%0d.almost_empty", i), almost_empty, i <= 2);
        end
`endif

        // Reset mid-operation at count 5
        do_reset();
        write_n(5);
        step(1'b1, 1'b1, 1'b1);
        check("rst5.count_before", count, 5);
        step(1'b0, 1'b0, 1'b0);
        check_reset_state("rst5");

        // Reset wins over a rejected write while full
        write_n(DEPTH);
        step(1'b1, 1'b0, 1'b1);
        check("rst_full.full_before", full, 1);
        step(1'b0, 1'b0, 1'b0);
        check_reset_state("rst_full");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
